keypad_matrix_scanner: RTL and testbench

Parametrised successor to the fixed 4x4 keypad scanner. It scans a ROWS x COLS switch matrix by driving one row low at a time and sampling the synchronised columns. Each key is debounced over several full scan frames, and press/release events are queued in a FIFO behind a valid/ready handshake. Game-control logic pops events or reads the debounced level vector directly; direction/action decoding moves downstream.

---
 rtl/kp_pkg.sv | 21 ++
 rtl/keypad_matrix_scanner_if.sv | 16 +
 rtl/kp_event_fifo.sv | 44 ++++
 rtl/keypad_matrix_scanner.sv | 151 +++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/kp_pkg.sv
// Shared types and constants for the keypad matrix scanner and its event FIFO.
package kp_pkg;

   typedef enum logic [0:0] {
      S_DRIVE = 1'b0,
      S_EMIT  = 1'b1
   } kp_state_t;

   localparam int CNT_W          = 4;
   localparam int DEF_ROWS       = 4;
   localparam int DEF_COLS       = 4;
   localparam int DEF_SETTLE     = 4;
   localparam int DEF_DEBOUNCE   = 3;
   localparam int DEF_FIFO_DEPTH = 8;

   // Event word is {press, key_index}; the press flag sits just above the index.
   function automatic int press_pos(input int kw);
      return kw;
   endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Event stream and overflow control between the scanner (master) and its consumer (slave).
interface keypad_matrix_scanner_if #(
   parameter int DW = 5
) ();

   // ev_data is held while ev_valid & ~ev_ready; ev_valid & ev_ready at a rising clk edge pops the head.
   logic          ev_valid;
   logic [DW-1:0] ev_data;
   logic          ev_ready;
   logic          overflow;
   logic          ovf_clr;

   modport master (output ev_valid, ev_data, overflow, input ev_ready, ovf_clr);
   modport slave  (input ev_valid, ev_data, overflow, output ev_ready, ovf_clr);

endinterface

// File: rtl/kp_event_fifo.sv
// Synchronous FIFO for key events; a push into a full FIFO is accepted when a pop happens in the same cycle.
module kp_event_fifo #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_pop;
   logic             do_push;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row-scanning keypad matrix reader: per-frame debounce of every key, press/release events queued in a FIFO.
module keypad_matrix_scanner
   import kp_pkg::*;
#(
   parameter int ROWS       = DEF_ROWS,
   parameter int COLS       = DEF_COLS,
   parameter int SETTLE     = DEF_SETTLE,
   parameter int DEBOUNCE   = DEF_DEBOUNCE,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [COLS-1:0]          col,
   output logic [ROWS-1:0]          row,
   output logic [ROWS*COLS-1:0]     key_state,
   keypad_matrix_scanner_if.master  ev,
   output kp_state_t                fsm_state
);

   localparam int NK = ROWS * COLS;
   localparam int KW = $clog2(NK);
   localparam int RW = $clog2(ROWS);
   localparam int SW = $clog2(SETTLE);
   localparam int PB = press_pos(KW);

   logic [COLS-1:0]  sync1;
   logic [COLS-1:0]  col_sync;
   kp_state_t        state;
   kp_state_t        state_nx;
   logic [RW-1:0]    r;
   logic [SW-1:0]    settle;
   logic [KW-1:0]    k;
   logic [NK-1:0]    frame_raw;
   logic [CNT_W-1:0] cnt [NK];
   logic [CNT_W-1:0] cur_cnt;
   logic             settle_last;
   logic             r_last;
   logic             k_last;
   logic             diff;
   logic             flip;
   logic             drop;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [KW:0]      ev_word;

   assign settle_last = (settle == SW'(SETTLE - 1));
   assign r_last      = (r == RW'(ROWS - 1));
   assign k_last      = (k == KW'(NK - 1));
   assign fsm_state   = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1    <= '0;
         col_sync <= '0;
      end else begin
         sync1    <= col;
         col_sync <= sync1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_DRIVE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_DRIVE: if (settle_last && r_last) state_nx = S_EMIT;
         S_EMIT:  if (k_last) state_nx = S_DRIVE;
         default: state_nx = S_DRIVE;
      endcase
   end

   always_comb begin
      row = '1;
      if (state == S_DRIVE) row[r] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r         <= '0;
         settle    <= '0;
         frame_raw <= '0;
      end else if (state == S_DRIVE) begin
         if (settle_last) begin
            settle <= '0;
            r      <= r_last ? '0 : r + 1'b1;
            for (int i = 0; i < ROWS; i++)
               if (int'(r) == i) frame_raw[i*COLS +: COLS] <= ~col_sync;
         end else begin
            settle <= settle + 1'b1;
         end
      end
   end

   // One key per S_EMIT cycle: flip when the mismatch has persisted for DEBOUNCE frames.
   always_comb begin
      cur_cnt         = cnt[k];
      diff            = frame_raw[k] ^ key_state[k];
      flip            = (state == S_EMIT) && diff && (cur_cnt == CNT_W'(DEBOUNCE - 1));
      ev_word         = '0;
      ev_word[PB]     = ~key_state[k];
      ev_word[KW-1:0] = k;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k         <= '0;
         key_state <= '0;
         for (int i = 0; i < NK; i++) cnt[i] <= '0;
      end else if (state == S_EMIT) begin
         k <= k_last ? '0 : k + 1'b1;
         if (!diff) begin
            cnt[k] <= '0;
         end else if (flip) begin
            cnt[k]       <= '0;
            key_state[k] <= ~key_state[k];
         end else begin
            cnt[k] <= cur_cnt + 1'b1;
         end
      end
   end

   assign pop         = !fifo_empty && ev.ev_ready;
   assign drop        = flip && fifo_full && !pop;
   assign ev.ev_valid = !fifo_empty;

   // A drop in the same cycle as ovf_clr keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             ev.overflow <= 1'b0;
      else if (drop)       ev.overflow <= 1'b1;
      else if (ev.ovf_clr) ev.overflow <= 1'b0;
   end

   kp_event_fifo #(
      .WIDTH (KW + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (flip),
      .din   (ev_word),
      .full  (fifo_full),
      .pop   (pop),
      .dout  (ev.ev_data),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: switch-matrix model, frame-level debounce model and event scoreboard.
module tb_keypad_matrix_scanner;
   import kp_pkg::*;

   localparam int ROWS       = 4;
   localparam int COLS       = 4;
   localparam int SETTLE     = 4;
   localparam int DEBOUNCE   = 3;
   localparam int FIFO_DEPTH = 8;
   localparam int NK         = ROWS * COLS;
   localparam int KW         = $clog2(NK);
   localparam int DRIVE_CYC  = ROWS * SETTLE;
   localparam int FRAME      = DRIVE_CYC + NK;
   localparam int NV         = 9;
   localparam int BURST_IDX  = 7;

   typedef struct {
      logic [NK-1:0] pat;
      int            frames;
      logic [NK-1:0] exp_ks;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [COLS-1:0] col;
   logic [ROWS-1:0] row;
   logic [NK-1:0]   key_state;
   kp_state_t       fsm_state;
   logic [NK-1:0]   pressed = '0;

   int            total = 0;
   int            bad = 0;
   logic [KW:0]   exp_q[$];
   logic          exp_ovf = 1'b0;
   logic [NK-1:0] m_state = '0;
   int            m_cnt [NK];
   time           t_prev = 0;
   time           t_last = 0;
   vec_t          vecs [NV];

   keypad_matrix_scanner_if #(.DW(KW + 1)) ev_if ();

   keypad_matrix_scanner #(
      .ROWS       (ROWS),
      .COLS       (COLS),
      .SETTLE     (SETTLE),
      .DEBOUNCE   (DEBOUNCE),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .col       (col),
      .row       (row),
      .key_state (key_state),
      .ev        (ev_if),
      .fsm_state (fsm_state)
   );

   always #5 clk = ~clk;

   // Closed switch pulls its column low while its row is driven low.
   always_comb begin
      col = '1;
      for (int rr = 0; rr < ROWS; rr++)
         for (int cc = 0; cc < COLS; cc++)
            if (!row[rr] && pressed[rr*COLS+cc]) col[cc] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      #1;
      if (!rst && ev_if.ev_valid && ev_if.ev_ready) begin
         t_prev = t_last;
         t_last = $time;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL ev_unexpected: got %0h expected no event at %0t", ev_if.ev_data, $time);
         end else begin
            check("ev_data", 32'(ev_if.ev_data), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic model_key(input int kk, input logic [NK-1:0] pat, input bit clr);
      bit dropped;
      dropped = 1'b0;
      if (pat[kk] == m_state[kk]) begin
         m_cnt[kk] = 0;
      end else begin
         m_cnt[kk]++;
         if (m_cnt[kk] == DEBOUNCE) begin
            m_cnt[kk]   = 0;
            m_state[kk] = ~m_state[kk];
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({m_state[kk], KW'(kk)});
            else begin
               dropped = 1'b1;
               exp_ovf = 1'b1;
            end
         end
      end
      if (clr && !dropped) exp_ovf = 1'b0;
   endtask

   // Runs one frame from its first-cycle negedge to the next frame's first negedge.
   task automatic run_frame(input logic [NK-1:0] pat, input int ready_on, input int clr_on);
      for (int j = 0; j < FRAME; j++) begin
         if (j == 0) pressed = pat;
         if (j == ready_on) ev_if.ev_ready = 1'b1;
         ev_if.ovf_clr = (j == clr_on);
         #2;
         if (j >= DRIVE_CYC) model_key(j - DRIVE_CYC, pat, j == clr_on);
         else if (j == clr_on) exp_ovf = 1'b0;
         @(negedge clk);
      end
      ev_if.ovf_clr = 1'b0;
      check("frame_key_state", 32'(key_state), 32'(m_state));
      check("frame_overflow", 32'(ev_if.overflow), 32'(exp_ovf));
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      pressed = '0;
      repeat (2) @(negedge clk);
      rst     = 1'b0;
      m_state = '0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      exp_q.delete();
      exp_ovf = 1'b0;
   endtask

   initial begin
      ev_if.ev_ready = 1'b1;
      ev_if.ovf_clr  = 1'b0;
      foreach (m_cnt[i]) m_cnt[i] = 0;

      vecs[0] = '{16'h0040, 2, 16'h0000};
      vecs[1] = '{16'h0040, 1, 16'h0040};
      vecs[2] = '{16'h0040, 2, 16'h0040};
      vecs[3] = '{16'h0000, 2, 16'h0040};
      vecs[4] = '{16'h0000, 1, 16'h0000};
      vecs[5] = '{16'h0200, 2, 16'h0000};
      vecs[6] = '{16'h0000, 3, 16'h0000};
      vecs[7] = '{16'h1008, 3, 16'h1008};
      vecs[8] = '{16'h0000, 3, 16'h0000};

      do_reset();
      check("rst_row", 32'(row), 32'h0000_000E);
      check("rst_key_state", 32'(key_state), 32'h0);
      check("rst_ev_valid", 32'(ev_if.ev_valid), 32'h0);
      check("rst_ev_data", 32'(ev_if.ev_data), 32'h0);
      check("rst_overflow", 32'(ev_if.overflow), 32'h0);
      check("rst_fsm", 32'(fsm_state), 32'(S_DRIVE));
      repeat (SETTLE - 1) @(negedge clk);
      check("row_hold", 32'(row), 32'h0000_000E);
      @(negedge clk);
      check("row_advance", 32'(row), 32'h0000_000D);
      repeat (FRAME - SETTLE) @(negedge clk);

      // Reset in the middle of an emit pass while key 5 is mid-debounce.
      repeat (2) run_frame(16'h0020, -1, -1);
      repeat (DRIVE_CYC + 3) @(negedge clk);
      do_reset();
      check("midrst_row", 32'(row), 32'h0000_000E);
      check("midrst_key_state", 32'(key_state), 32'h0);
      check("midrst_ev_valid", 32'(ev_if.ev_valid), 32'h0);
      check("midrst_overflow", 32'(ev_if.overflow), 32'h0);

      for (int i = 0; i < NV; i++) begin
         for (int f = 0; f < vecs[i].frames; f++) run_frame(vecs[i].pat, -1, -1);
         check($sformatf("vec%0d_key_state", i), 32'(key_state), 32'(vecs[i].exp_ks));
         if (i == BURST_IDX) check("burst_gap", 32'(t_last - t_prev), 32'd90);
      end

      for (int i = 0; i < 6; i++) begin
         logic [NK-1:0] pat;
         int            n;
         pat = NK'($urandom_range(0, 16'hFFFF));
         n   = $urandom_range(1, 4);
         repeat (n) run_frame(pat, -1, -1);
      end
      repeat (4) run_frame('0, -1, -1);

      // Nine presses with the consumer stalled: the ninth is dropped.
      ev_if.ev_ready = 1'b0;
      repeat (3) run_frame(16'h01FF, -1, -1);
      check("ovf_set", 32'(ev_if.overflow), 32'h1);
      check("ovf_key_state", 32'(key_state), 32'h01FF);
      check("ovf_ev_valid", 32'(ev_if.ev_valid), 32'h1);
      run_frame(16'h01FF, 0, -1);
      check("drain_ev_valid", 32'(ev_if.ev_valid), 32'h0);
      check("drain_ovf_held", 32'(ev_if.overflow), 32'h1);
      run_frame(16'h01FF, -1, 2);
      check("ovf_cleared", 32'(ev_if.overflow), 32'h0);

      // Fill the FIFO exactly, then pop in the same cycle as the next push.
      ev_if.ev_ready = 1'b0;
      repeat (3) run_frame(16'h0100, -1, -1);
      check("full_ev_valid", 32'(ev_if.ev_valid), 32'h1);
      check("full_no_ovf", 32'(ev_if.overflow), 32'h0);
      repeat (2) run_frame(16'h0500, -1, -1);
      run_frame(16'h0500, DRIVE_CYC + 10, -1);
      run_frame(16'h0500, -1, -1);
      check("poppush_no_ovf", 32'(ev_if.overflow), 32'h0);
      check("poppush_key_state", 32'(key_state), 32'h0500);

      // Drop on the same cycle as ovf_clr: set wins.
      ev_if.ev_ready = 1'b0;
      repeat (3) run_frame(16'h003F, -1, -1);
      repeat (2) run_frame(16'h803F, -1, -1);
      run_frame(16'h803F, -1, FRAME - 1);
      check("drop_clr_ovf", 32'(ev_if.overflow), 32'h1);
      check("drop_clr_key_state", 32'(key_state), 32'h803F);
      run_frame(16'h803F, 0, -1);
      run_frame(16'h803F, -1, 0);
      check("final_overflow", 32'(ev_if.overflow), 32'h0);
      check("final_ev_valid", 32'(ev_if.ev_valid), 32'h0);
      check("sb_drained", 32'(exp_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
